// File: rtl/simple_ram_pkg.sv
// rtl/simple_ram_pkg.sv - shared defaults, sweep state type and word-index decode for simple_ram_array
package simple_ram_pkg;

    localparam int SIMPLE_RAM_DATA_W   = 32;
    localparam int SIMPLE_RAM_ADDR_W   = 32;
    localparam int SIMPLE_RAM_DEPTH_LG = 8;

    // Widest byte address the index helper accepts; callers zero-extend into it
    localparam int SIMPLE_RAM_ADDR_MAX = 64;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Word index of a byte address: drop the byte offset, keep depth_lg bits so
    // higher addresses alias modulo the array depth
    function automatic logic [SIMPLE_RAM_ADDR_MAX-1:0] idx(
        input logic [SIMPLE_RAM_ADDR_MAX-1:0] addr,
        input int unsigned                    depth_lg
    );
        logic [SIMPLE_RAM_ADDR_MAX-1:0] mask;
        mask = (SIMPLE_RAM_ADDR_MAX'(1) << depth_lg) - SIMPLE_RAM_ADDR_MAX'(1);
        return (addr >> 2) & mask;
    endfunction

endpackage

// File: rtl/simple_ram_clear_fsm.sv
// rtl/simple_ram_clear_fsm.sv - post-reset clear sweep and array port arbitration
module simple_ram_clear_fsm
    import simple_ram_pkg::*;
#(
    parameter int DATA_W   = SIMPLE_RAM_DATA_W,
    parameter int DEPTH_LG = SIMPLE_RAM_DEPTH_LG
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                wr,
    input  logic [DEPTH_LG-1:0] word_idx,
    input  logic [DATA_W-1:0]   data,
    output logic                busy,
    output logic                mem_we,
    output logic                mem_re,
    output logic [DEPTH_LG-1:0] mem_addr,
    output logic [DATA_W-1:0]   mem_wdata
);

    state_t              state;
    logic [DEPTH_LG-1:0] ptr;
    logic                clearing;

    // Sweep one word per cycle from 0 to DEPTH-1, then hand the port to the requester
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            busy  <= 1'b1;
            ptr   <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + DEPTH_LG'(1);
            if (ptr == '1) begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end

    // Reset suppresses every array access; during the sweep the requester is ignored
    assign clearing  = (state == CLEAR);
    assign mem_we    = !rst && (clearing || (enable && wr));
    assign mem_re    = !rst && !clearing && enable && !wr;
    assign mem_addr  = clearing ? ptr : word_idx;
    assign mem_wdata = clearing ? '0 : data;

endmodule

// File: rtl/simple_ram_array.sv
// rtl/simple_ram_array.sv - single-port word memory with registered read and post-reset clear
module simple_ram_array
    import simple_ram_pkg::*;
#(
    parameter int DATA_W   = SIMPLE_RAM_DATA_W,
    parameter int ADDR_W   = SIMPLE_RAM_ADDR_W,
    parameter int DEPTH_LG = SIMPLE_RAM_DEPTH_LG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic              enable,
    output logic [DATA_W-1:0] q,
    output logic              busy
);

    localparam int DEPTH = 2 ** DEPTH_LG;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH_LG-1:0] word_idx;
    logic                mem_we;
    logic                mem_re;
    logic [DEPTH_LG-1:0] mem_addr;
    logic [DATA_W-1:0]   mem_wdata;

    assign word_idx = DEPTH_LG'(idx(SIMPLE_RAM_ADDR_MAX'(addr), DEPTH_LG));

    simple_ram_clear_fsm #(
        .DATA_W   (DATA_W),
        .DEPTH_LG (DEPTH_LG)
    ) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .wr        (wr),
        .word_idx  (word_idx),
        .data      (data),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    // Single write port shared by the sweep and the requester
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Registered read; q only moves on an accepted read and is zeroed by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (mem_re) begin
            q <= mem[mem_addr];
        end
    end

endmodule

// File: tb/tb_simple_ram_array.sv
// tb/tb_simple_ram_array.sv - directed self-checking bench for simple_ram_array
module tb_simple_ram_array;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic [31:0] addr;
    logic        wr;
    logic        enable;
    logic [31:0] q;
    logic        busy;

    int checks;
    int errors;

    simple_ram_array dut (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .addr   (addr),
        .wr     (wr),
        .enable (enable),
        .q      (q),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        enable = 1'b1;
        wr     = 1'b1;
        addr   = a;
        data   = d;
        tick();
        enable = 1'b0;
        wr     = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        enable = 1'b1;
        wr     = 1'b0;
        addr   = a;
        tick();
        enable = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
    endtask

    int          n;
    logic [31:0] q_or;
    logic [31:0] alias_addrs [4];

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        data   = '0;
        addr   = '0;
        wr     = 1'b0;
        enable = 1'b0;

        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_q", q, 32'd0);

        // Release reset; a write to 0x8 late in the sweep must be dropped
        rst  = 1'b0;
        n    = 0;
        q_or = '0;
        while (busy && n < 1000) begin
            if (n >= 250) begin
                enable = 1'b1;
                wr     = 1'b1;
                addr   = 32'h8;
                data   = 32'hA5A5A5A5;
            end
            tick();
            n++;
            q_or |= q;
        end
        enable = 1'b0;
        wr     = 1'b0;
        check("sweep_cycles", 32'(n), 32'd256);
        check("sweep_q_zero", q_or, 32'd0);
        check("busy_after_sweep", 32'(busy), 32'd0);

        // Write then read back-to-back
        do_write(32'h10, 32'hDEADBEEF);
        check("q_during_write0", q, 32'd0);
        do_read(32'h10);
        check("read_10", q, 32'hDEADBEEF);
        do_write(32'h14, 32'h11111111);
        check("q_during_write1", q, 32'hDEADBEEF);

        do_read(32'h0);
        check("read_0", q, 32'd0);
        do_read(32'h3FC);
        check("read_3fc", q, 32'd0);
        do_read(32'h8);
        check("dropped_busy_write", q, 32'd0);

        // Aliasing across high bits and byte offsets
        do_write(32'h00000404, 32'h12345678);
        alias_addrs[0] = 32'h00000004;
        alias_addrs[1] = 32'h80000004;
        alias_addrs[2] = 32'h00000005;
        alias_addrs[3] = 32'h00000007;
        for (int i = 0; i < 4; i++) begin
            do_read(32'h14);
            check("alias_sep", q, 32'h11111111);
            do_read(alias_addrs[i]);
            check($sformatf("alias_%08h", alias_addrs[i]), q, 32'h12345678);
        end
        do_read(32'h6);
        check("alias_6", q, 32'h12345678);

        // Enable gating: write without enable must not land, q holds
        do_read(32'h10);
        enable = 1'b0;
        wr     = 1'b1;
        addr   = 32'h20;
        data   = 32'hFFFFFFFF;
        tick();
        tick();
        tick();
        check("q_hold_disabled", q, 32'hDEADBEEF);
        wr = 1'b0;
        do_read(32'h20);
        check("gated_write", q, 32'd0);

        // Reset during a read wins and zeroes q
        do_read(32'h4);
        check("pre_rst_read", q, 32'h12345678);
        enable = 1'b1;
        wr     = 1'b0;
        addr   = 32'h10;
        rst    = 1'b1;
        tick();
        check("rst_read_q", q, 32'd0);
        check("rst_read_busy", 32'(busy), 32'd1);
        rst    = 1'b0;
        enable = 1'b0;

        // Mid-sweep reset restarts the full count
        for (int i = 0; i < 100; i++) tick();
        check("mid_sweep_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_idle(n);
        check("restart_cycles", 32'(n), 32'd256);

        do_read(32'h10);
        check("cleared_10", q, 32'd0);
        do_read(32'h404);
        check("cleared_404", q, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
